// File: rtl/mux_select_sequencer.sv
// Round-robin sequencer for a 4:1 tri-state mux stage.
// It grants one requesting source at a time and holds each grant for a
// bounded dwell. Every channel change passes through a one-cycle gap with
// en low, so two bufif1 drivers never share the mux output. All outputs are
// decoded from registered state only, so there is no path from req/lock to
// the outputs.
module mux_select_sequencer #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       lock,
  output logic       s1,
  output logic       s0,
  output logic       en,
  output logic [3:0] gnt
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] DWELL_C = CW'(DWELL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cur_q, cur_d;   // granted channel, also drives the select lines
  logic [1:0]    ptr_q, ptr_d;   // last released channel
  logic [CW-1:0] cnt_q, cnt_d;   // consecutive grant cycles, saturating at DWELL
  logic [3:0]    others;

  // Round-robin pick: first set bit searching last+1, last+2, last+3, last.
  // The loop runs from the farthest candidate down so the nearest one wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [3:0] r);
    logic [1:0] cand;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (r[cand]) rr_pick = cand;
    end
  endfunction

  // State and datapath registers; reset leaves ptr at 3 so channel 0 is
  // searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values computed by the comb logic.
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: grant, dwell expiry, break-before-make gap.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    others  = req & ~(4'b0001 << cur_q);

    unique case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          cur_d   = rr_pick(ptr_q, req);
          cnt_d   = CW'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[cur_q]) begin
          state_d = GAP;
        end else if (cnt_q == DWELL_C && !lock && others != 4'b0000) begin
          state_d = GAP;
        end else if (cnt_q != DWELL_C) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        // ptr takes cur on this edge, so search from cur directly.
        ptr_d = cur_q;
        if (req != 4'b0000) begin
          cur_d   = rr_pick(cur_q, req);
          cnt_d   = CW'(1);
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state only; select follows cur, which
  // changes only on the edge that enters GRANT.
  always_comb begin
    en       = (state_q == GRANT);
    gnt      = en ? (4'b0001 << cur_q) : 4'b0000;
    {s1, s0} = cur_q;
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Bench for mux_select_sequencer: directed scenarios followed by random
// request/lock traffic, all compared against a cycle-level reference model
// of the grant rules.
module tb_mux_select_sequencer;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       lock;
  logic       s1, s0, en;
  logic [3:0] gnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: granted/gap flags, channel, cycles held, last released.
  bit m_grant, m_gap;
  int m_ch, m_held, m_last;

  mux_select_sequencer #(.DWELL(DWELL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .lock (lock),
    .s1   (s1),
    .s0   (s0),
    .en   (en),
    .gnt  (gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return last;
  endfunction

  task automatic model_reset();
    m_grant = 0; m_gap = 0; m_ch = 0; m_held = 0; m_last = 3;
  endtask

  // Advance the model by one clock edge with the inputs present at that edge.
  task automatic model_step(input logic [3:0] r, input logic l);
    logic [3:0] rest;
    if (m_grant) begin
      rest = r & ~(4'b0001 << m_ch);
      if (!r[m_ch] || (m_held >= DWELL && !l && rest != 0)) begin
        m_grant = 0;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_last = m_ch;
      m_gap  = 0;
      if (r != 0) begin
        m_ch = model_pick(m_last, r); m_held = 1; m_grant = 1;
      end
    end else if (r != 0) begin
      m_ch = model_pick(m_last, r); m_held = 1; m_grant = 1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = m_grant ? (4'b0001 << m_ch) : 4'b0000;
    check({tag, ".en"},  4'(en), 4'(m_grant));
    check({tag, ".sel"}, 4'({s1, s0}), 4'(m_ch));
    check({tag, ".gnt"}, gnt, exp_gnt);
  endtask

  // One clock edge: model sees the same inputs, outputs compared 1 unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step(req, lock);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; lock = 1'b0;
    model_reset();
    @(negedge clk);
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset and idle
    do_reset();
    check("reset.gnt0", gnt, 4'b0000);
    for (int i = 0; i < 10; i++) tick("idle");
    check("idle.en", 4'(en), 4'b0000);

    // Single requester held well past DWELL, then released
    req = 4'b0100;
    tick("single.first");
    check("single.gnt", gnt, 4'b0100);
    check("single.sel", 4'({s1, s0}), 4'b0010);
    for (int i = 0; i < DWELL + 20; i++) tick("single.hold");
    check("single.held", gnt, 4'b0100);
    req = 4'b0000;
    tick("single.gap");
    check("single.gap_en", 4'(en), 4'b0000);
    tick("single.idle");
    check("single.idle_sel", 4'({s1, s0}), 4'b0010);

    // Full contention from reset: order 0,1,2,3,0, each DWELL on + 1 gap
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < DWELL; c++) begin
        tick("contend.on");
        check("contend.gnt", gnt, 4'b0001 << (g % 4));
      end
      tick("contend.gap");
      check("contend.gap_en", 4'(en), 4'b0000);
      check("contend.gap_sel", 4'({s1, s0}), 4'(g % 4));
    end

    // Lock holds channel 0 beyond DWELL; release switches via one gap
    do_reset();
    req = 4'b0011; lock = 1'b1;
    for (int i = 0; i < 10; i++) tick("lock.hold");
    check("lock.held", gnt, 4'b0001);
    lock = 1'b0;
    tick("lock.gap");
    check("lock.gap_en", 4'(en), 4'b0000);
    tick("lock.next");
    check("lock.next_gnt", gnt, 4'b0010);

    // Request drop coinciding with dwell expiry: single gap, then next channel
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < DWELL; i++) tick("simul.on");
    req = 4'b0010;
    tick("simul.gap");
    check("simul.gap_en", 4'(en), 4'b0000);
    tick("simul.next");
    check("simul.next_gnt", gnt, 4'b0010);

    // Asynchronous reset in the middle of a channel 2 grant
    do_reset();
    req = 4'b0100;
    tick("areset.grant");
    tick("areset.grant2");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("areset.en", 4'(en), 4'b0000);
    check("areset.gnt", gnt, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1100;
    tick("areset.after");
    check("areset.first", gnt, 4'b0100);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      lock = ($urandom_range(0, 7) == 0);
      tick("random");
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model("random.areset");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
